// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared constants, state enum and error codes for the instruction memory loader
package im_pkg;

    localparam int IM_BYTE_DEPTH = 256;
    localparam int ADDR_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ADDR,
        HDR_LEN,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;

endpackage

// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream loader that writes payload bytes into instruction memory
module im_loader #(
    parameter int IM_BYTE_DEPTH = im_pkg::IM_BYTE_DEPTH,
    parameter int ADDR_W        = im_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_inCmd,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_inst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code
);
    import im_pkg::*;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          remaining;
    logic [7:0]          csum;
    logic                xfer;
    logic [ADDR_W:0]     frame_end;
    logic                range_bad;

    // A byte moves only when the stream offers it and the current state wants one.
    assign xfer      = i_byte_valid && o_byte_ready;

    // End of frame computed one bit wider so S+N cannot wrap; exactly the depth is still legal.
    assign frame_end = {1'b0, start_addr} + {1'b0, ADDR_W'(i_byte)};
    assign range_bad = frame_end > (ADDR_W+1)'(IM_BYTE_DEPTH);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus Moore status outputs.
    always_comb begin
        state_nxt    = state;
        o_byte_ready = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = HDR_ADDR;
            end
            HDR_ADDR: begin
                o_byte_ready = 1'b1;
                if (xfer) state_nxt = HDR_LEN;
            end
            HDR_LEN: begin
                o_byte_ready = 1'b1;
                if (xfer) begin
                    if (range_bad)          state_nxt = ERR;
                    else if (i_byte == 8'd0) state_nxt = CHK;
                    else                    state_nxt = DATA;
                end
            end
            DATA: begin
                o_byte_ready = 1'b1;
                if (xfer && remaining == 8'd1) state_nxt = CHK;
            end
            CHK: begin
                o_byte_ready = 1'b1;
                if (xfer) state_nxt = (i_byte == csum) ? DONE : ERR;
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) state_nxt = HDR_ADDR;
            end
            ERR: begin
                o_err = 1'b1;
                if (i_start) state_nxt = HDR_ADDR;
            end
            default: state_nxt = IDLE;
        endcase
        // The final strobe lands while already in CHK, so the pending write also holds busy.
        o_busy = o_byte_ready | o_inCmd;
    end

    // Frame datapath: header capture, write strobe generation, running checksum, error code.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_addr <= '0;
            wr_addr    <= '0;
            remaining  <= '0;
            csum       <= '0;
            o_inCmd    <= 1'b0;
            o_addr     <= '0;
            o_inst     <= '0;
            o_err_code <= ERR_NONE;
        end else begin
            o_inCmd <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (i_start) o_err_code <= ERR_NONE;
                end
                HDR_ADDR: begin
                    if (xfer) start_addr <= ADDR_W'(i_byte);
                end
                HDR_LEN: begin
                    if (xfer) begin
                        remaining <= i_byte;
                        wr_addr   <= start_addr;
                        csum      <= 8'd0;
                        if (range_bad) o_err_code <= ERR_RANGE;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        o_addr    <= wr_addr;
                        o_inst    <= i_byte;
                        o_inCmd   <= 1'b1;
                        wr_addr   <= wr_addr + 1'b1;
                        remaining <= remaining - 8'd1;
                        csum      <= csum ^ i_byte;
                    end
                end
                CHK: begin
                    if (xfer && i_byte != csum) o_err_code <= ERR_CSUM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - self-checking bench for im_loader with a write scoreboard and frame table
module tb_im_loader;
    import im_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic       o_inCmd;
    logic [7:0] o_addr;
    logic [7:0] o_inst;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_err_code;

    always #5 clk = ~clk;

    im_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_inCmd      (o_inCmd),
        .o_addr       (o_addr),
        .o_inst       (o_inst),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] b;
        int          n;
        bit          gaps;
        bit          done;
        bit          err;
        logic [1:0]  code;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    vec_t       vecs [8];
    wr_t        exp_q [$];
    logic [7:0] mem [0:255];

    function automatic vec_t mk(input int n, input logic [63:0] b, input bit gaps,
                                input bit done, input bit err, input logic [1:0] code);
        vec_t v;
        v.b = b; v.n = n; v.gaps = gaps; v.done = done; v.err = err; v.code = code;
        return v;
    endfunction

    function automatic logic [7:0] at(input vec_t v, input int i);
        return v.b[63-8*i -: 8];
    endfunction

    // Instruction memory model
    always @(posedge clk) if (o_inCmd) mem[o_addr] <= o_inst;

    // Strobe monitor: pops the scoreboard on each strobe, checks hold between strobes
    logic [7:0] prev_addr = 8'd0;
    logic [7:0] prev_inst = 8'd0;
    bit         prev_rst  = 1'b1;
    wr_t        w;
    always @(negedge clk) begin
        if (o_inCmd) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("strobe_addr", int'(o_addr), int'(w.a));
                chk("strobe_data", int'(o_inst), int'(w.d));
            end
        end else if (!rst && !prev_rst) begin
            chk("addr_hold", int'(o_addr), int'(prev_addr));
            chk("inst_hold", int'(o_inst), int'(prev_inst));
        end
        prev_addr = o_addr;
        prev_inst = o_inst;
        prev_rst  = rst;
    end

    task automatic send_frame(input int k, input int max_acc);
        vec_t v;
        int   s, n, idx, wait_c;
        bit   legal, acc;
        v = vecs[k];
        s = int'(at(v, 0));
        n = int'(at(v, 1));
        legal  = (s + n) <= 256;
        idx    = 0;
        wait_c = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        while (idx < v.n && idx < max_acc) begin
            i_byte       = at(v, idx);
            i_byte_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (v.gaps) i_start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = i_byte_valid && o_byte_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (legal && idx >= 2 && idx < 2 + n)
                    exp_q.push_back(wr_t'{a: 8'(s + idx - 2), d: at(v, idx)});
                idx++;
                wait_c = 0;
            end else begin
                wait_c++;
                if (wait_c > 40) begin
                    chk("byte_timeout", idx, v.n);
                    break;
                end
            end
        end
        i_byte_valid = 1'b0;
        i_start      = 1'b0;
    endtask

    task automatic check_status(input int k);
        vec_t v;
        int   s, n;
        v = vecs[k];
        s = int'(at(v, 0));
        n = int'(at(v, 1));
        chk($sformatf("v%0d_done", k), int'(o_done), int'(v.done));
        chk($sformatf("v%0d_err", k), int'(o_err), int'(v.err));
        chk($sformatf("v%0d_code", k), int'(o_err_code), int'(v.code));
        chk($sformatf("v%0d_busy", k), int'(o_busy), 0);
        chk($sformatf("v%0d_drained", k), exp_q.size(), 0);
        if (v.done)
            for (int j = 0; j < n; j++)
                chk($sformatf("v%0d_mem_%0h", k, s + j), int'(mem[s + j]), int'(at(v, 2 + j)));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, int'(o_byte_ready), 0);
        chk({tag, "_incmd"}, int'(o_inCmd), 0);
        chk({tag, "_addr"}, int'(o_addr), 0);
        chk({tag, "_inst"}, int'(o_inst), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_err"}, int'(o_err), 0);
        chk({tag, "_code"}, int'(o_err_code), 0);
    endtask

    initial begin
        vecs[0] = mk(6, 64'h10_03_AA_55_0F_F0_00_00, 1'b0, 1'b1, 1'b0, ERR_NONE);
        vecs[1] = mk(2, 64'hFE_03_00_00_00_00_00_00, 1'b0, 1'b0, 1'b1, ERR_RANGE);
        vecs[2] = mk(5, 64'hFE_02_11_22_33_00_00_00, 1'b0, 1'b1, 1'b0, ERR_NONE);
        vecs[3] = mk(5, 64'h00_02_12_34_00_00_00_00, 1'b0, 1'b0, 1'b1, ERR_CSUM);
        vecs[4] = mk(3, 64'h40_00_00_00_00_00_00_00, 1'b0, 1'b1, 1'b0, ERR_NONE);
        vecs[5] = mk(3, 64'h40_00_01_00_00_00_00_00, 1'b0, 1'b0, 1'b1, ERR_CSUM);
        vecs[6] = mk(6, 64'h10_03_AA_55_0F_F0_00_00, 1'b1, 1'b1, 1'b0, ERR_NONE);
        vecs[7] = mk(6, 64'h80_03_C3_3C_99_66_00_00, 1'b0, 1'b1, 1'b0, ERR_NONE);

        rst = 1'b1; i_start = 1'b0; i_byte = 8'd0; i_byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            send_frame(k, 99);
            repeat (4) @(posedge clk);
            #1;
            check_status(k);
            if (k == 0 || k == 6)
                chk($sformatf("v%0d_fetch_10", k), int'({mem[8'h10], mem[8'h11]}), 16'hAA55);
        end

        // Reset after the first of three payload bytes has been accepted
        send_frame(7, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle("midrst");
        chk("midrst_drained", exp_q.size(), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_quiet_busy", int'(o_busy), 0);
        chk("midrst_kept_byte", int'(mem[8'h80]), 8'hC3);

        send_frame(7, 99);
        repeat (4) @(posedge clk);
        #1;
        check_status(7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Upstream program loader for the byte-addressed instruction memory.
- Accepts a framed byte stream over a valid/ready handshake: start address, length, payload, XOR checksum.
- Writes each payload byte into instruction memory by driving its load-strobe, address and data inputs, then reports done or error.
- Keeps o_busy high during loading so the core's fetch/PC logic can hold off.

Parameters:
- IM_BYTE_DEPTH, 256, instruction memory size in bytes; the frame range check uses this limit.
- ADDR_W, 8, address width; must satisfy 2**ADDR_W == IM_BYTE_DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  begin a new frame; honoured only in IDLE, DONE or ERR
- i_byte  in  8  stream byte
- i_byte_valid  in  1  i_byte is valid this cycle
- o_byte_ready  out  1  loader accepts i_byte this cycle
- o_inCmd  out  1  one-cycle write strobe to instruction memory
- o_addr  out  ADDR_W  instruction memory byte address
- o_inst  out  8  instruction memory write data
- o_busy  out  1  frame in progress
- o_done  out  1  last frame completed cleanly
- o_err  out  1  last frame failed
- o_err_code  out  2  01 = range error, 10 = checksum error, 00 = none

Behaviour:
- Clocking and reset: single clock domain, all state on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including o_addr, o_inst and o_err_code.
- Reset mid-frame: the loader returns to IDLE on the next edge and issues no further strobes. Bytes already written stay written.
- Handshake: a byte transfers on a rising edge where i_byte_valid && o_byte_ready. o_byte_ready is decoded from state only (Moore): 1 in HDR_ADDR, HDR_LEN, DATA and CHK, else 0. Throughput is one byte per cycle.
- Frame format: byte0 = start address S, byte1 = length N (0..255), then N payload bytes, then checksum C = XOR of the payload bytes (0x00 when N=0).
- States and transitions:
  - IDLE: i_start -> HDR_ADDR.
  - HDR_ADDR: on transfer, latch S; -> HDR_LEN.
  - HDR_LEN: on transfer, latch N and clear the running XOR. If S+N, computed at 9 bits, exceeds IM_BYTE_DEPTH -> ERR with code 01 and no writes. Else if N=0 -> CHK. Else -> DATA with remaining count = N and write address = S.
  - DATA: on each transfer, register o_addr = write address, o_inst = i_byte and o_inCmd = 1 for exactly the next cycle. Then increment the address, decrement the count and fold the byte into the XOR. When the count reaches 0 -> CHK.
  - CHK: on transfer, if i_byte == running XOR -> DONE, else -> ERR with code 10.
  - DONE and ERR: outputs hold. i_start -> HDR_ADDR, which clears o_done, o_err and o_err_code.
- Write latency: the strobe is asserted on the cycle after the byte is accepted, and memory captures the byte on the edge that ends that strobe cycle.
- Strobe hold-off: o_inCmd is 0 in every cycle with no pending write. o_addr and o_inst hold their last values between strobes.
- o_busy is 1 in HDR_ADDR, HDR_LEN, DATA and CHK. It stays 1 through the cycle carrying the final strobe, even though the state is already CHK.
- Range boundary: S+N == IM_BYTE_DEPTH is legal; the last write goes to address IM_BYTE_DEPTH-1. The address never wraps.
- i_start while busy is ignored. i_byte_valid outside the ready states is ignored.
- A checksum error leaves the memory contents written; software must reload the frame.

Decomposition:
- Shared package im_pkg holds:
  - IM_BYTE_DEPTH and ADDR_W;
  - the state enum (IDLE, HDR_ADDR, HDR_LEN, DATA, CHK, DONE, ERR);
  - the error codes ERR_NONE, ERR_RANGE, ERR_CSUM.
- Single module; no sub-module needed. The handshake decode and checksum fold are a few lines each.

Test Plan:
- Basic load: i_start, then stream 0x10, 0x03, 0xAA, 0x55, 0x0F, 0xF0 with valid held high.
  - Expect three strobes at addresses 0x10, 0x11, 0x12 with data AA, 55, 0F, each one cycle after acceptance.
  - Then o_done=1, o_err=0; memory fetch at 0x10 returns 0xAA55.
- Range error: frame 0xFE, 0x03 -> o_err=1, o_err_code=01, no o_inCmd pulses. Boundary: 0xFE, 0x02, 0x11, 0x22, 0x33 -> writes to FE and FF, then done.
- Checksum error: 0x00, 0x02, 0x12, 0x34, 0x00 -> two writes, then o_err=1, o_err_code=10.
- Zero length: 0x40, 0x00, 0x00 -> no strobes, o_done=1 after 3 transfers. A bad checksum of 0x01 -> code 10.
- Back-pressure and gaps: toggle i_byte_valid randomly on the basic-load frame.
  - Identical memory contents.
  - Exactly one strobe per payload byte.
  - o_addr and o_inst stable between strobes.
  - i_start pulses mid-frame have no effect.
- Reset mid-DATA: assert rst after 1 of 3 payload bytes.
  - Next cycle: IDLE, all outputs 0, no further strobes.
  - A subsequent full frame then loads correctly.
